// File: rtl/fft_butterfly_pkg.sv
// Shared constants and helpers for the radix-2 FFT butterfly.
// The twiddle format is Q2.(DW-2), so 1.0 is 2^(DW-2).
package fft_butterfly_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CMD_WIDTH  = 3;
    localparam int TW_FRAC        = DEF_DATA_WIDTH - 2;

    // Clamp a wide signed value to the range of a dw-bit two's complement number.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction
endpackage

// File: rtl/fft_butterfly_cmul.sv
// Registered complex multiply b*w followed by the twiddle-format shift; one cycle of latency.
// The outputs carry DW+3 bits, enough for |b*w| up to 2^(DW+1) without wrap.
module cmul_q14
    import fft_butterfly_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TW_FRAC    = DEF_DATA_WIDTH - 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2*DATA_WIDTH-1:0]       i_b,
    input  logic [2*DATA_WIDTH-1:0]       i_w,
    output logic signed [DATA_WIDTH+2:0]  o_bw_re,
    output logic signed [DATA_WIDTH+2:0]  o_bw_im
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int FW = 2 * DATA_WIDTH + 1;

    logic signed [DATA_WIDTH-1:0] w_br, w_bi, w_wr, w_wi;
    logic signed [PW-1:0]         r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [FW-1:0]         w_re_full, w_im_full;

    assign w_br = $signed(i_b[PW-1:DATA_WIDTH]);
    assign w_bi = $signed(i_b[DATA_WIDTH-1:0]);
    assign w_wr = $signed(i_w[PW-1:DATA_WIDTH]);
    assign w_wi = $signed(i_w[DATA_WIDTH-1:0]);

    // Full-width products; even (-2^(DW-1))^2 fits in 2*DW signed bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_rr <= '0;
            r_p_ii <= '0;
            r_p_ri <= '0;
            r_p_ir <= '0;
        end else begin
            r_p_rr <= PW'(w_br) * PW'(w_wr);
            r_p_ii <= PW'(w_bi) * PW'(w_wi);
            r_p_ri <= PW'(w_br) * PW'(w_wi);
            r_p_ir <= PW'(w_bi) * PW'(w_wr);
        end
    end

    assign w_re_full = FW'(r_p_rr) - FW'(r_p_ii);
    assign w_im_full = FW'(r_p_ri) + FW'(r_p_ir);

    assign o_bw_re = (DATA_WIDTH + 3)'(w_re_full >>> TW_FRAC);
    assign o_bw_im = (DATA_WIDTH + 3)'(w_im_full >>> TW_FRAC);
endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: out_a = (a + b*w)/2, out_b = (a - b*w)/2, two-cycle pipeline.
// The command tag rides the same two register stages as the data.
module fft_butterfly
    import fft_butterfly_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CMD_WIDTH  = DEF_CMD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*DATA_WIDTH-1:0] in_a,
    input  logic [2*DATA_WIDTH-1:0] in_b,
    input  logic [2*DATA_WIDTH-1:0] w,
    input  logic [CMD_WIDTH-1:0]    m_in,
    output logic [2*DATA_WIDTH-1:0] out_a,
    output logic [2*DATA_WIDTH-1:0] out_b,
    output logic [CMD_WIDTH-1:0]    m_out
);
    localparam int SUM_W = DATA_WIDTH + 4;

    logic [2*DATA_WIDTH-1:0]      r_a1;
    logic [CMD_WIDTH-1:0]         r_m1;
    logic [2*DATA_WIDTH-1:0]      r_out_a, r_out_b;
    logic [CMD_WIDTH-1:0]         r_m2;
    logic signed [DATA_WIDTH+2:0] w_bw_re, w_bw_im;
    logic signed [DATA_WIDTH-1:0] w_a_re, w_a_im;
    logic signed [SUM_W-1:0]      w_sum_ar, w_sum_ai, w_sum_br, w_sum_bi;
    logic signed [DATA_WIDTH-1:0] w_sat_ar, w_sat_ai, w_sat_br, w_sat_bi;

    cmul_q14 #(
        .DATA_WIDTH (DATA_WIDTH),
        .TW_FRAC    (DATA_WIDTH - 2)
    ) u_cmul (
        .clk     (clk),
        .rst     (rst),
        .i_b     (in_b),
        .i_w     (w),
        .o_bw_re (w_bw_re),
        .o_bw_im (w_bw_im)
    );

    assign w_a_re = $signed(r_a1[2*DATA_WIDTH-1:DATA_WIDTH]);
    assign w_a_im = $signed(r_a1[DATA_WIDTH-1:0]);

    // Halving by arithmetic shift floors toward -inf, matching the bw shift.
    assign w_sum_ar = (SUM_W'(w_a_re) + SUM_W'(w_bw_re)) >>> 1;
    assign w_sum_ai = (SUM_W'(w_a_im) + SUM_W'(w_bw_im)) >>> 1;
    assign w_sum_br = (SUM_W'(w_a_re) - SUM_W'(w_bw_re)) >>> 1;
    assign w_sum_bi = (SUM_W'(w_a_im) - SUM_W'(w_bw_im)) >>> 1;

    assign w_sat_ar = DATA_WIDTH'(saturate(64'(w_sum_ar), DATA_WIDTH));
    assign w_sat_ai = DATA_WIDTH'(saturate(64'(w_sum_ai), DATA_WIDTH));
    assign w_sat_br = DATA_WIDTH'(saturate(64'(w_sum_br), DATA_WIDTH));
    assign w_sat_bi = DATA_WIDTH'(saturate(64'(w_sum_bi), DATA_WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a1    <= '0;
            r_m1    <= '0;
            r_out_a <= '0;
            r_out_b <= '0;
            r_m2    <= '0;
        end else begin
            r_a1    <= in_a;
            r_m1    <= m_in;
            r_out_a <= {w_sat_ar, w_sat_ai};
            r_out_b <= {w_sat_br, w_sat_bi};
            r_m2    <= r_m1;
        end
    end

    assign out_a = r_out_a;
    assign out_b = r_out_b;
    assign m_out = r_m2;
endmodule

// File: tb/tb_fft_butterfly.sv
// Self-checking bench for fft_butterfly: fixed vectors, back-to-back, reset flush, random streams.
module tb_fft_butterfly;
    logic        clk;
    logic        rst;
    logic [31:0] in_a, in_b, w;
    logic [2:0]  m_in;
    logic [31:0] out_a, out_b;
    logic [2:0]  m_out;

    int checks = 0;
    int errors = 0;

    fft_butterfly dut (
        .clk   (clk),
        .rst   (rst),
        .in_a  (in_a),
        .in_b  (in_b),
        .w     (w),
        .m_in  (m_in),
        .out_a (out_a),
        .out_b (out_b),
        .m_out (m_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    function automatic longint clamp16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Reference: complex arithmetic on plain integers, floor division by powers of two.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] tw,
                                  output logic [31:0] oa, output logic [31:0] ob);
        longint ar, ai, br, bi, wr, wi, pr, pi;
        int     r0, i0, r1, i1;
        ar = longint'($signed(a[31:16]));  ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));  bi = longint'($signed(b[15:0]));
        wr = longint'($signed(tw[31:16])); wi = longint'($signed(tw[15:0]));
        pr = (br * wr - bi * wi) >>> 14;
        pi = (br * wi + bi * wr) >>> 14;
        r0 = int'(clamp16((ar + pr) >>> 1));
        i0 = int'(clamp16((ai + pi) >>> 1));
        r1 = int'(clamp16((ar - pr) >>> 1));
        i1 = int'(clamp16((ai - pi) >>> 1));
        oa = pk(r0, i0);
        ob = pk(r1, i1);
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] tw, input logic [2:0] m);
        in_a = a; in_b = b; w = tw; m_in = m;
    endtask

    task automatic test_reset();
        drive(pk(1000, -1000), pk(2000, 3000), pk(16384, 0), 3'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_a !== 32'h0 || out_b !== 32'h0 || m_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_first_cycle: got a=%h b=%h m=%0d want 0", out_a, out_b, m_out);
        end
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_a !== 32'h0 || out_b !== 32'h0 || m_out !== 3'd0) begin
            errors++;
            $display("FAIL zero_inputs: got a=%h b=%h m=%0d want 0", out_a, out_b, m_out);
        end
    endtask

    // Spec vectors 1,2,3,6 each applied once, followed by an idle cycle.
    task automatic test_vectors();
        logic [31:0] va[4], vb[4], vw[4], ea[4], eb[4];
        logic [2:0]  vm[4];
        va[0] = pk(16384, 0);    vb[0] = pk(16384, -110);  vw[0] = pk(16384, 0);       vm[0] = 3'd1;
        ea[0] = pk(16384, -55);  eb[0] = pk(0, 55);
        va[1] = pk(16384, -110); vb[1] = pk(16384, 0);     vw[1] = pk(11585, -11585); vm[1] = 3'd2;
        ea[1] = pk(13984, -5848); eb[1] = pk(2399, 5737);
        va[2] = pk(32767, 0);    vb[2] = pk(32767, 32767); vw[2] = pk(16384, -16384); vm[2] = 3'd3;
        ea[2] = pk(32767, 0);    eb[2] = pk(-16384, 0);
        va[3] = pk(384, -1212);  vb[3] = pk(0, 0);         vw[3] = $urandom;          vm[3] = 3'd6;
        ea[3] = pk(192, -606);   eb[3] = pk(192, -606);
        for (int k = 0; k < 4; k++) begin
            drive(va[k], vb[k], vw[k], vm[k]);
            @(posedge clk); #1;
            drive(0, 0, 0, 0);
            @(posedge clk); #1;
            checks++;
            if (out_a !== ea[k] || out_b !== eb[k] || m_out !== vm[k]) begin
                errors++;
                $display("FAIL vector_%0d: got a=%h b=%h m=%0d want a=%h b=%h m=%0d",
                         k, out_a, out_b, m_out, ea[k], eb[k], vm[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va[3], vb[3], vw[3], ea[3], eb[3];
        logic [2:0]  vm[3];
        va[0] = pk(16384, 0);    vb[0] = pk(16384, -110);  vw[0] = pk(16384, 0);       vm[0] = 3'd1;
        ea[0] = pk(16384, -55);  eb[0] = pk(0, 55);
        va[1] = pk(16384, -110); vb[1] = pk(16384, 0);     vw[1] = pk(11585, -11585); vm[1] = 3'd2;
        ea[1] = pk(13984, -5848); eb[1] = pk(2399, 5737);
        va[2] = pk(32767, 0);    vb[2] = pk(32767, 32767); vw[2] = pk(16384, -16384); vm[2] = 3'd3;
        ea[2] = pk(32767, 0);    eb[2] = pk(-16384, 0);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drive(va[k], vb[k], vw[k], vm[k]);
            else       drive(0, 0, 0, 0);
            @(posedge clk); #1;
            if (k >= 1) begin
                checks++;
                if (out_a !== ea[k-1] || out_b !== eb[k-1] || m_out !== vm[k-1]) begin
                    errors++;
                    $display("FAIL b2b_%0d: got a=%h b=%h m=%0d want a=%h b=%h m=%0d",
                             k - 1, out_a, out_b, m_out, ea[k-1], eb[k-1], vm[k-1]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] ea, eb;
        drive(pk(16384, 0), pk(16384, -110), pk(16384, 0), 3'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(pk(9999, 9999), pk(9999, 9999), pk(16384, 0), 3'd7);
        @(posedge clk); #1;
        checks++;
        if (out_a !== 32'h0 || out_b !== 32'h0 || m_out !== 3'd0) begin
            errors++;
            $display("FAIL flush_during_rst: got a=%h b=%h m=%0d want 0", out_a, out_b, m_out);
        end
        rst = 1'b0;
        drive(pk(16384, -110), pk(16384, 0), pk(11585, -11585), 3'd2);
        @(posedge clk); #1;
        checks++;
        if (out_a !== 32'h0 || out_b !== 32'h0 || m_out !== 3'd0) begin
            errors++;
            $display("FAIL flush_after_rst: got a=%h b=%h m=%0d want 0", out_a, out_b, m_out);
        end
        drive(0, 0, 0, 0);
        @(posedge clk); #1;
        ea = pk(13984, -5848);
        eb = pk(2399, 5737);
        checks++;
        if (out_a !== ea || out_b !== eb || m_out !== 3'd2) begin
            errors++;
            $display("FAIL post_rst_vector2: got a=%h b=%h m=%0d want a=%h b=%h m=2",
                     out_a, out_b, m_out, ea, eb);
        end
    endtask

    // Random stream; every few samples forces extreme operands (including w = -2.0).
    task automatic test_random(input int n);
        logic [31:0] ea[$], eb[$];
        logic [2:0]  em[$];
        logic [31:0] a, b, tw, xa, xb;
        logic [2:0]  m;
        int          sel;
        for (int k = 0; k < n + 1; k++) begin
            if (k < n) begin
                a = $urandom; b = $urandom; tw = $urandom; m = 3'($urandom);
                sel = int'($urandom_range(0, 5));
                if (sel == 0) tw = pk(-32768, int'($urandom_range(0, 1)) * -32768);
                if (sel == 1) begin a = pk(32767, -32768); b = pk(-32768, -32768); end
                if (sel == 2) tw = pk(16384, 0);
                model(a, b, tw, xa, xb);
                ea.push_back(xa); eb.push_back(xb); em.push_back(m);
                drive(a, b, tw, m);
            end else begin
                drive(0, 0, 0, 0);
            end
            @(posedge clk); #1;
            if (k >= 1) begin
                xa = ea.pop_front(); xb = eb.pop_front(); m = em.pop_front();
                checks++;
                if (out_a !== xa || out_b !== xb || m_out !== m) begin
                    errors++;
                    $display("FAIL random_%0d: got a=%h b=%h m=%0d want a=%h b=%h m=%0d",
                             k - 1, out_a, out_b, m_out, xa, xb, m);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0);
        test_reset();
        test_vectors();
        test_back_to_back();
        test_mid_reset();
        test_random(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
